// File: rtl/wb_bridge_rr_arbiter.sv
// Round-robin arbiter that shares one Wishbone slave port among NREQ masters.
// A grant is held for the whole locked cycle of its owner. Each handover passes
// through a one-cycle RELEASE gap so the downstream bridge always sees a fresh
// rising edge of cyc. A stalled strobe is ended with a forced error ack.
module wb_bridge_rr_arbiter #(
    parameter int          NREQ     = 4,
    parameter int          WID      = 256,
    parameter int          TIMEOUT  = 1023,
    // Error code returned on a timeout (the fta_bus ERR encoding).
    parameter logic [2:0]  ERR_CODE = 3'b001
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NREQ-1:0]         req_cyc_i,
    input  logic [NREQ-1:0]         req_stb_i,
    input  logic [NREQ-1:0]         req_we_i,
    input  logic [NREQ*WID/8-1:0]   req_sel_i,
    input  logic [NREQ*32-1:0]      req_adr_i,
    input  logic [NREQ*WID-1:0]     req_dat_i,
    output logic [NREQ-1:0]         req_ack_o,
    output logic [2:0]              req_err_o,
    output logic [WID-1:0]          req_dat_o,
    output logic [NREQ-1:0]         grant_o,
    output logic                    m_cs_o,
    output logic                    m_cyc_o,
    output logic                    m_stb_o,
    output logic                    m_we_o,
    output logic [WID/8-1:0]        m_sel_o,
    output logic [31:0]             m_adr_o,
    output logic [WID-1:0]          m_dat_o,
    input  logic                    m_ack_i,
    input  logic [2:0]              m_err_i,
    input  logic [WID-1:0]          m_dat_i
);

    localparam int         SW      = WID / 8;
    localparam int         IW      = $clog2(NREQ);
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    // Handshake: while granted, the owner's cyc/stb pass straight through and
    // m_ack_i completes one beat per cycle it is high; ack reaches only the
    // owner, and only while the owner still holds cyc.
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [9:0]        tcnt_q, tcnt_d;

    logic              cyc_g, stb_g, we_g;
    logic [SW-1:0]     sel_g;
    logic [31:0]       adr_g;
    logic [WID-1:0]    dat_g;
    logic              pick_found;
    logic [IW-1:0]     pick_idx, cand;
    logic              in_grant, timeout_fire, ack_fwd;

    // Select the signals of the currently granted requester (all zero with no grant).
    always_comb begin
        cyc_g = 1'b0;
        stb_g = 1'b0;
        we_g  = 1'b0;
        sel_g = '0;
        adr_g = '0;
        dat_g = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (grant_q[n]) begin
                cyc_g = req_cyc_i[n];
                stb_g = req_stb_i[n];
                we_g  = req_we_i[n];
                sel_g = req_sel_i[n*SW +: SW];
                adr_g = req_adr_i[n*32 +: 32];
                dat_g = req_dat_i[n*WID +: WID];
            end
        end
    end

    // Round-robin search: first requesting index above the last grant, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (!pick_found && req_cyc_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign in_grant     = (state_q == ST_GRANT);
    assign timeout_fire = in_grant && cyc_g && stb_g && !m_ack_i && (tcnt_q == TO_LAST);
    assign ack_fwd      = in_grant && cyc_g && (m_ack_i || timeout_fire);

    assign grant_o   = grant_q;
    assign req_ack_o = ack_fwd ? grant_q : '0;
    assign req_err_o = !in_grant ? 3'b000 : (timeout_fire ? ERR_CODE : m_err_i);
    assign req_dat_o = in_grant ? m_dat_i : '0;
    assign m_cyc_o   = in_grant && cyc_g && !timeout_fire;
    assign m_cs_o    = m_cyc_o;
    assign m_stb_o   = in_grant && stb_g;
    assign m_we_o    = in_grant && we_g;
    assign m_sel_o   = in_grant ? sel_g : '0;
    assign m_adr_o   = in_grant ? adr_g : '0;
    assign m_dat_o   = in_grant ? dat_g : '0;

    // Next-state logic: arbitration, grant hold, release gap and timeout counter.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (pick_found) begin
                    state_d = ST_GRANT;
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    ptr_d   = pick_idx;
                end
            end
            ST_GRANT: begin
                if (m_ack_i) begin
                    tcnt_d = '0;
                end else if (m_stb_o && (tcnt_q != 10'h3FF)) begin
                    tcnt_d = tcnt_q + 10'd1;
                end
                if (!cyc_g || timeout_fire) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; requester 0 has first priority after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NREQ - 1);
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule
